uart_tx_fifo: RTL and testbench

Byte buffer and launcher that sits directly upstream of UART_TX. It accepts bytes from the system at full clock rate into a circular FIFO. It hands the bytes one at a time to UART_TX through that block's i_tx_dv/i_tx_byte handshake, pacing each launch on UART_TX's o_tx_done. This decouples producers from the serial bit rate of 217 clocks per bit at a 40 ns clock.

---
 rtl/uart_tx_fifo.sv | 114 +++++++++++
 tb/tb_uart_tx_fifo.sv | 199 +++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO that feeds a UART transmitter through its dv/byte handshake.
// One byte is launched at a time, paced by the transmitter's done pulse.
module uart_tx_fifo #(
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_wr_dv,
    input  logic [7:0]        i_wr_byte,
    output logic              o_full,
    output logic              o_empty,
    output logic [ADDR_W:0]   o_count,
    output logic              o_overflow,
    output logic              o_tx_dv,
    output logic [7:0]        o_tx_byte,
    input  logic              i_tx_active,
    input  logic              i_tx_done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        GAP  = 2'd2
    } state_t;

    localparam logic [ADDR_W:0] FULL_COUNT = (ADDR_W + 1)'(DEPTH);

    state_t            state;
    logic [7:0]        mem [DEPTH];
    logic [ADDR_W-1:0] wr_ptr;
    logic [ADDR_W-1:0] rd_ptr;
    logic              wr_accept;
    logic              pop;
    logic [ADDR_W:0]   count_next;

    // NOTE: every signal assigned in always_comb gets a default first, so no
    // path leaves it unassigned and no latch is inferred.
    always_comb begin
        wr_accept  = i_wr_dv && !o_full;
        pop        = (state == IDLE) && !o_empty && !i_tx_active;
        count_next = o_count;
        case ({wr_accept, pop})
            2'b10:   count_next = o_count + 1'b1;
            2'b01:   count_next = o_count - 1'b1;
            default: count_next = o_count;
        endcase
    end

    // NOTE: the storage array has no reset; its contents are meaningless until
    // written, and leaving it out keeps it mappable to plain registers/RAM.
    always_ff @(posedge i_clk) begin
        if (wr_accept) begin
            mem[wr_ptr] <= i_wr_byte;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values, independent of statement order.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            wr_ptr     <= '0;
            o_count    <= '0;
            o_full     <= 1'b0;
            o_empty    <= 1'b1;
            o_overflow <= 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            // A write against a full FIFO is dropped and remembered until reset.
            if (i_wr_dv && o_full) begin
                o_overflow <= 1'b1;
            end
            o_count <= count_next;
            o_full  <= (count_next == FULL_COUNT);
            o_empty <= (count_next == '0);
        end
    end

    // Launch FSM: GAP gives the transmitter one cycle to leave its cleanup state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state     <= IDLE;
            rd_ptr    <= '0;
            o_tx_dv   <= 1'b0;
            o_tx_byte <= 8'h00;
        end else begin
            o_tx_dv <= 1'b0;
            case (state)
                IDLE: begin
                    if (pop) begin
                        o_tx_byte <= mem[rd_ptr];
                        o_tx_dv   <= 1'b1;
                        rd_ptr    <= rd_ptr + 1'b1;
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (i_tx_done) begin
                        state <= GAP;
                    end
                end
                GAP: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Randomized bench for uart_tx_fifo: a byte-queue reference model plus a short
// transmitter stub that answers each launch with active/done after a few cycles.
module tb_uart_tx_fifo;

    localparam int DEPTH  = 16;
    localparam int ADDR_W = 4;

    logic              clk = 1'b0;
    logic              i_rst;
    logic              i_wr_dv;
    logic [7:0]        i_wr_byte;
    logic              o_full;
    logic              o_empty;
    logic [ADDR_W:0]   o_count;
    logic              o_overflow;
    logic              o_tx_dv;
    logic [7:0]        o_tx_byte;
    logic              i_tx_active;
    logic              i_tx_done;

    uart_tx_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_wr_dv     (i_wr_dv),
        .i_wr_byte   (i_wr_byte),
        .o_full      (o_full),
        .o_empty     (o_empty),
        .o_count     (o_count),
        .o_overflow  (o_overflow),
        .o_tx_dv     (o_tx_dv),
        .o_tx_byte   (o_tx_byte),
        .i_tx_active (i_tx_active),
        .i_tx_done   (i_tx_done)
    );

    always #5 clk = ~clk;

    int tests_run = 0;
    int tests_failed = 0;

    // Reference model: pending bytes, last launched byte, sticky overflow and
    // launch pacing expressed as edge numbers.
    logic [7:0] mq[$];
    logic       exp_dv = 1'b0;
    logic [7:0] exp_byte = 8'h00;
    logic       exp_ovf = 1'b0;
    bit         outstanding = 1'b0;
    int         last_done = -100;
    int         cyc = 0;
    bit         armed = 1'b0;

    // Transmitter stub state.
    bit         stall = 1'b0;
    int         stub_left = 0;
    int         launches = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        tests_run++;
        if (got !== exp) begin
            tests_failed++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, got, exp);
        end
    endtask

    task automatic step(input logic rst, input logic wr, input logic [7:0] b);
        logic act;
        logic done;
        logic launch;
        logic accept;
        int   e;

        done = 1'b0;
        if (stub_left > 0) begin
            stub_left--;
            if (stub_left == 0) done = 1'b1;
        end
        if (o_tx_dv === 1'b1) begin
            stub_left = $urandom_range(3, 12);
            launches++;
        end
        act = stall || (stub_left > 0);

        i_rst       = rst;
        i_wr_dv     = wr;
        i_wr_byte   = b;
        i_tx_active = act;
        i_tx_done   = done;

        e = cyc + 1;
        if (rst) begin
            mq.delete();
            exp_dv      = 1'b0;
            exp_byte    = 8'h00;
            exp_ovf     = 1'b0;
            outstanding = 1'b0;
            last_done   = -100;
            armed       = 1'b1;
        end else begin
            launch = !outstanding && (e >= last_done + 2) && (mq.size() > 0) && !act;
            accept = wr && (mq.size() < DEPTH);
            if (wr && !accept) exp_ovf = 1'b1;
            if (done && outstanding) begin
                outstanding = 1'b0;
                last_done   = e;
            end
            exp_dv = 1'b0;
            if (launch) begin
                exp_byte    = mq.pop_front();
                exp_dv      = 1'b1;
                outstanding = 1'b1;
            end
            if (accept) mq.push_back(b);
        end
        cyc = e;

        @(negedge clk);
        if (armed) begin
            check("count",    32'(o_count),    32'(mq.size()));
            check("empty",    32'(o_empty),    32'(mq.size() == 0));
            check("full",     32'(o_full),     32'(mq.size() == DEPTH));
            check("overflow", 32'(o_overflow), 32'(exp_ovf));
            check("tx_dv",    32'(o_tx_dv),    32'(exp_dv));
            check("tx_byte",  32'(o_tx_byte),  32'(exp_byte));
        end
    endtask

    task automatic drain(input int limit);
        int n;
        n = 0;
        while ((mq.size() > 0 || outstanding || stub_left > 0) && n < limit) begin
            step(1'b0, 1'b0, 8'h00);
            n++;
        end
        check("drain_left", 32'(mq.size()), 32'd0);
        repeat (3) step(1'b0, 1'b0, 8'h00);
    endtask

    initial begin
        int peak;

        // Reset held with a write strobe asserted; nothing may be stored.
        repeat (3) step(1'b1, 1'b1, 8'hAA);
        repeat (4) step(1'b0, 1'b0, 8'h00);

        // Single byte: launch appears one cycle after the write edge.
        step(1'b0, 1'b1, 8'h3F);
        step(1'b0, 1'b0, 8'h00);
        check("single_launch_byte", 32'(o_tx_byte), 32'h3F);
        drain(200);

        // Burst of five on consecutive cycles; occupancy peaks at four.
        peak = 0;
        for (int i = 1; i <= 5; i++) begin
            step(1'b0, 1'b1, 8'(i));
            if (int'(o_count) > peak) peak = int'(o_count);
        end
        check("burst_peak", 32'(peak), 32'd4);
        drain(500);

        // Stalled transmitter: 17 writes, the last one overflows.
        stall = 1'b1;
        for (int i = 0; i < 17; i++) step(1'b0, 1'b1, 8'(8'h10 + i));
        check("ovf_full", 32'(o_full), 32'd1);
        repeat (5) step(1'b0, 1'b0, 8'h00);
        stall = 1'b0;
        drain(1000);
        check("ovf_sticky", 32'(o_overflow), 32'd1);

        // Wrap-around: four bursts of ten with drains in between.
        for (int k = 0; k < 4; k++) begin
            for (int i = 0; i < 10; i++) step(1'b0, 1'b1, 8'($urandom_range(0, 255)));
            drain(1000);
        end

        // Random traffic with occasional stalls.
        for (int blk = 0; blk < 30; blk++) begin
            stall = ($urandom_range(0, 4) == 0);
            for (int i = 0; i < 50; i++)
                step(1'b0, ($urandom_range(0, 9) < 3), 8'($urandom_range(0, 255)));
        end
        stall = 1'b0;
        drain(2000);

        // Reset while bytes are queued and one is in flight.
        step(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'(8'hC0 + i));
        check("mid_queued", 32'(o_count), 32'd5);
        step(1'b1, 1'b0, 8'h00);
        check("mid_ovf_clear", 32'(o_overflow), 32'd0);
        launches = 0;
        repeat (30) step(1'b0, 1'b0, 8'h00);
        check("mid_no_launch", 32'(launches), 32'd0);
        check("mid_count", 32'(o_count), 32'd0);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
